// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters,
// with bounded burst lock. Optional per-requester grant counters: SRAM_ARB_STATS_EN.
module sram_rr_arbiter #(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned AW       = 12,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    lock,
   input  logic [NUM_REQ-1:0]    wr,
   input  logic [NUM_REQ*AW-1:0] addr,
   input  logic [NUM_REQ*DW-1:0] wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  sram_csn,
   output logic                  sram_wen,
   output logic [AW-1:0]         sram_a,
   output logic [DW-1:0]         sram_d,
   input  logic [DW-1:0]         sram_q
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic               held_q, held_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;
   logic               sram_csn_q, sram_csn_d;
   logic               sram_wen_q, sram_wen_d;
   logic [AW-1:0]      sram_a_q, sram_a_d;
   logic [DW-1:0]      sram_d_q, sram_d_d;
   logic               p1_vld_q, p1_vld_d;
   logic [IW-1:0]      p1_id_q, p1_id_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

   logic               gnt_any;
   logic [IW-1:0]      gnt_id;
   logic               hold_path;
   logic               other_req;
   logic [NUM_REQ-1:0] gnt_c;

   // held_q marks that last cycle's grant carried lock; it is the "owner" for the hold path
   always_comb begin
      gnt_any   = 1'b0;
      gnt_id    = '0;
      hold_path = 1'b0;
      gnt_c     = '0;
      other_req = |(req & ~(NUM_REQ'(1) << owner_q));
      if (hresetn) begin
         if (held_q && req[owner_q] && ((32'(hold_cnt_q) < MAX_HOLD) || !other_req)) begin
            hold_path = 1'b1;
            gnt_any   = 1'b1;
            gnt_id    = owner_q;
         end else begin
            for (int unsigned i = 1; i <= NUM_REQ; i++) begin
               if (!gnt_any && req[IW'((32'(rr_ptr_q) + i) % NUM_REQ)]) begin
                  gnt_any = 1'b1;
                  gnt_id  = IW'((32'(rr_ptr_q) + i) % NUM_REQ);
               end
            end
         end
         if (gnt_any) gnt_c[gnt_id] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      held_d     = 1'b0;
      hold_cnt_d = '0;
      sram_csn_d = 1'b1;
      sram_wen_d = 1'b1;
      sram_a_d   = sram_a_q;
      sram_d_d   = sram_d_q;
      p1_vld_d   = 1'b0;
      p1_id_d    = gnt_id;
      rvalid_d   = '0;
      if (gnt_any) begin
         sram_csn_d = 1'b0;
         sram_wen_d = ~wr[gnt_id];
         sram_a_d   = addr[32'(gnt_id)*AW +: AW];
         sram_d_d   = wdata[32'(gnt_id)*DW +: DW];
         rr_ptr_d   = gnt_id;
         owner_d    = gnt_id;
         held_d     = lock[gnt_id];
         p1_vld_d   = ~wr[gnt_id];
         if (hold_path)
            hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
         else
            hold_cnt_d = 8'd1;
      end
      if (p1_vld_q) rvalid_d[p1_id_q] = 1'b1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rr_ptr_q   <= IW'(NUM_REQ - 1);
         owner_q    <= '0;
         held_q     <= 1'b0;
         hold_cnt_q <= '0;
         sram_csn_q <= 1'b1;
         sram_wen_q <= 1'b1;
         sram_a_q   <= '0;
         sram_d_q   <= '0;
         p1_vld_q   <= 1'b0;
         p1_id_q    <= '0;
         rvalid_q   <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         held_q     <= held_d;
         hold_cnt_q <= hold_cnt_d;
         sram_csn_q <= sram_csn_d;
         sram_wen_q <= sram_wen_d;
         sram_a_q   <= sram_a_d;
         sram_d_q   <= sram_d_d;
         p1_vld_q   <= p1_vld_d;
         p1_id_q    <= p1_id_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign gnt      = gnt_c;
   assign rvalid   = rvalid_q;
   assign rdata    = sram_q;
   assign sram_csn = sram_csn_q;
   assign sram_wen = sram_wen_q;
   assign sram_a   = sram_a_q;
   assign sram_d   = sram_d_q;

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];
   logic [15:0] cnt_d [NUM_REQ];

   // clear wins over a same-cycle grant; counters stick at all-ones
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (stats_clr)
            cnt_d[i] = '0;
         else if (gnt_c[i] && (cnt_q[i] != 16'hFFFF))
            cnt_d[i] = cnt_q[i] + 16'd1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter (NUM_REQ=2) with a behavioural SRAM
// and a read scoreboard keyed on expected id, data and arrival cycle.
module tb_sram_rr_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          hclk = 1'b0;
   logic          hresetn;
   logic [1:0]    req, lock, wr;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1;
   logic [1:0]    gnt, rvalid;
   logic [DW-1:0] rdata;
   logic          sram_csn, sram_wen;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;
   logic          stats_clr;
`ifdef SRAM_ARB_STATS_EN
   logic [31:0]   grant_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } rd_t;
   rd_t sbq[$];

   logic [31:0] mem    [4096];
   logic [31:0] shadow [4096];

   always #5 hclk = ~hclk;
   always @(posedge hclk) cyc <= cyc + 1;

   always @(posedge hclk) begin
      if (!sram_csn) begin
         if (!sram_wen) mem[sram_a] <= sram_d;
         else sram_q <= mem[sram_a];
      end
   end

   sram_rr_arbiter #(.NUM_REQ(2), .AW(AW), .DW(DW), .MAX_HOLD(16)) dut (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .req      (req),
      .lock     (lock),
      .wr       (wr),
      .addr     ({a1, a0}),
      .wdata    ({d1, d0}),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .sram_csn (sram_csn),
      .sram_wen (sram_wen),
      .sram_a   (sram_a),
      .sram_d   (sram_d),
      .sram_q   (sram_q)
`ifdef SRAM_ARB_STATS_EN
      ,
      .stats_clr(stats_clr),
      .grant_cnt(grant_cnt)
`endif
   );

   // Read-data monitor: pops scoreboard on rvalid, flags spurious/missing reads
   always @(negedge hclk) begin
      if (!hresetn) begin
         sbq.delete();
      end else if (rvalid !== 2'b00) begin
         n_checks++;
         if (sbq.size() == 0) begin
            $display("FAIL rd_spurious rvalid=%b rdata=%h required no rvalid cyc=%0d", rvalid, rdata, cyc);
         end else begin
            rd_t e;
            e = sbq.pop_front();
            if (rvalid !== (2'b01 << e.id) || rdata !== e.data || cyc != e.due)
               $display("FAIL rd_data rvalid=%b rdata=%h cyc=%0d required rvalid=%b rdata=%h cyc=%0d",
                        rvalid, rdata, cyc, 2'b01 << e.id, e.data, e.due);
            else
               n_pass++;
         end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
         rd_t e;
         e = sbq.pop_front();
         n_checks++;
         $display("FAIL rd_missing id=%0d due=%0d now=%0d rvalid=%b", e.id, e.due, cyc, rvalid);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic set_in(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                         input logic [DW-1:0] y0, input logic [DW-1:0] y1);
      req = r; lock = l; wr = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
   endtask

   // Called at posedge+1; checks the grant, updates the model, returns at next posedge+1
   task automatic cycle(input logic [1:0] exp_gnt, input string tag);
      int            id;
      logic          e_wen;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      #3;
      n_checks++;
      if (gnt !== exp_gnt)
         $display("FAIL %s_gnt gnt=%b required=%b cyc=%0d", tag, gnt, exp_gnt, cyc);
      else
         n_pass++;
      id    = exp_gnt[1] ? 1 : 0;
      e_a   = id ? a1 : a0;
      e_d   = id ? d1 : d0;
      e_wen = ~wr[id];
      if (exp_gnt != 2'b00) begin
         if (wr[id]) shadow[e_a] = e_d;
         else sbq.push_back('{id, shadow[e_a], cyc + 2});
      end
      @(posedge hclk);
      #1;
      n_checks++;
      if (exp_gnt == 2'b00) begin
         if (sram_csn !== 1'b1 || sram_wen !== 1'b1)
            $display("FAIL %s_idle csn=%b wen=%b required csn=1 wen=1", tag, sram_csn, sram_wen);
         else
            n_pass++;
      end else begin
         if (sram_csn !== 1'b0 || sram_wen !== e_wen || sram_a !== e_a || (e_wen == 1'b0 && sram_d !== e_d))
            $display("FAIL %s_cmd csn=%b wen=%b a=%h d=%h required csn=0 wen=%b a=%h d=%h",
                     tag, sram_csn, sram_wen, sram_a, sram_d, e_wen, e_a, e_d);
         else
            n_pass++;
      end
   endtask

   task automatic do_reset();
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      stats_clr = 1'b0;
      hresetn = 1'b0;
      @(posedge hclk); #1;
      @(posedge hclk); #1;
      hresetn = 1'b1;
   endtask

   task automatic test_reset();
      hresetn   = 1'b0;
      stats_clr = 1'b0;
      set_in(2'b11, 2'b11, 2'b01, 12'h001, 12'h002, 32'h1, 32'h2);
      for (int i = 0; i < 3; i++) begin
         @(posedge hclk); #1;
         n_checks++;
         if (sram_csn !== 1'b1 || sram_wen !== 1'b1 || gnt !== 2'b00 || rvalid !== 2'b00 ||
             sram_a !== '0 || sram_d !== '0)
            $display("FAIL reset_state csn=%b wen=%b gnt=%b rvalid=%b a=%h d=%h required 1 1 00 00 0 0",
                     sram_csn, sram_wen, gnt, rvalid, sram_a, sram_d);
         else
            n_pass++;
      end
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      hresetn = 1'b1;
      for (int i = 0; i < 3; i++) cycle(2'b00, "reset_idle");
      // read in flight, then reset lands before its data returns
      set_in(2'b01, 2'b00, 2'b01, 12'h0AA, '0, 32'hA5A5A5A5, '0);
      cycle(2'b01, "reset_wr");
      set_in(2'b01, 2'b00, 2'b00, 12'h0AA, '0, '0, '0);
      cycle(2'b01, "reset_rd");
      #1;
      hresetn = 1'b0;
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      n_checks++;
      if (sram_csn !== 1'b1 || rvalid !== 2'b00 || gnt !== 2'b00)
         $display("FAIL reset_async csn=%b rvalid=%b gnt=%b required 1 00 00", sram_csn, rvalid, gnt);
      else
         n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge hclk); #1;
         n_checks++;
         if (rvalid !== 2'b00 || sram_csn !== 1'b1)
            $display("FAIL reset_drop rvalid=%b csn=%b required 00 1", rvalid, sram_csn);
         else
            n_pass++;
      end
      hresetn = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      set_in(2'b01, 2'b00, 2'b01, 12'h123, '0, 32'hDEADBEEF, '0);
      cycle(2'b01, "wr_rd_w");
      set_in(2'b01, 2'b00, 2'b00, 12'h123, '0, '0, '0);
      cycle(2'b01, "wr_rd_r");
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 3; i++) cycle(2'b00, "wr_rd_idle");
   endtask

   task automatic test_round_robin();
      do_reset();
      set_in(2'b11, 2'b00, 2'b11, 12'h300, 12'h301, 32'hAAAA0000, 32'hBBBB0000);
      for (int i = 0; i < 6; i++) cycle((i % 2 == 0) ? 2'b01 : 2'b10, "rr");
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle(2'b00, "rr_idle");
   endtask

   task automatic test_lock_bound();
      do_reset();
      for (int c = 0; c < 40; c++) begin
         set_in({c >= 2, 1'b1}, 2'b01, 2'b11, AW'(12'h100 + c), 12'h200, 32'(c), 32'hFEED0000 + 32'(c));
         cycle((c == 16 || c == 33) ? 2'b10 : 2'b01, "lock");
      end
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle(2'b00, "lock_idle");
   endtask

   task automatic test_read_routing();
      do_reset();
      set_in(2'b01, 2'b00, 2'b01, 12'h010, '0, 32'h11111111, '0);
      cycle(2'b01, "route_w0");
      set_in(2'b10, 2'b00, 2'b10, '0, 12'h020, '0, 32'h22222222);
      cycle(2'b10, "route_w1");
      set_in(2'b01, 2'b00, 2'b00, 12'h010, '0, '0, '0);
      cycle(2'b01, "route_r0");
      set_in(2'b10, 2'b00, 2'b00, '0, 12'h020, '0, '0);
      cycle(2'b10, "route_r1");
      set_in(2'b11, 2'b00, 2'b00, 12'h020, 12'h010, '0, '0);
      cycle(2'b01, "route_both0");
      cycle(2'b10, "route_both1");
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 3; i++) cycle(2'b00, "route_idle");
   endtask

   task automatic test_back_to_back();
      int            ptr;
      logic [1:0]    r, w, e;
      logic [AW-1:0] pick [3];
      pick[0] = 12'h010; pick[1] = 12'h020; pick[2] = 12'h123;
      do_reset();
      ptr = 1;
      for (int c = 0; c < 30; c++) begin
         r = 2'($urandom_range(0, 3));
         w = 2'($urandom_range(0, 3));
         set_in(r, 2'b00, w, pick[$urandom_range(0, 2)], pick[$urandom_range(0, 2)],
                $urandom, $urandom);
         e = 2'b00;
         if (r[(ptr + 1) % 2]) begin e[(ptr + 1) % 2] = 1'b1; ptr = (ptr + 1) % 2; end
         else if (r[ptr]) e[ptr] = 1'b1;
         cycle(e, "b2b");
      end
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 3; i++) cycle(2'b00, "b2b_idle");
   endtask

`ifdef SRAM_ARB_STATS_EN
   task automatic test_stats();
      logic [15:0] c0, c1;
      do_reset();
      set_in(2'b10, 2'b00, 2'b10, '0, 12'h400, '0, 32'h5);
      for (int i = 0; i < 5; i++) cycle(2'b10, "stats_g");
      c0 = grant_cnt[15:0];
      c1 = grant_cnt[31:16];
      n_checks++;
      if (c1 !== 16'd5 || c0 !== 16'd0)
         $display("FAIL stats_count cnt1=%0d cnt0=%0d required 5 0", c1, c0);
      else
         n_pass++;
      stats_clr = 1'b1;
      cycle(2'b10, "stats_clr");
      stats_clr = 1'b0;
      c1 = grant_cnt[31:16];
      n_checks++;
      if (c1 !== 16'd0)
         $display("FAIL stats_clear cnt1=%0d required 0", c1);
      else
         n_pass++;
      set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
      cycle(2'b00, "stats_idle");
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_lock_bound();
      test_read_routing();
      test_back_to_back();
`ifdef SRAM_ARB_STATS_EN
      test_stats();
`endif
      repeat (3) begin @(posedge hclk); #1; end
      n_checks++;
      if (sbq.size() != 0)
         $display("FAIL rd_drain outstanding=%0d required 0", sbq.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one 32-bit single-port SRAM (4096 words, active-low chip select and write enable, registered read output) between NUM_REQ word-access requesters, for example the AHB SRAM controller and a DMA/fill engine.
- Arbitration is round-robin. Bursts can be held with a lock input, bounded by MAX_HOLD.
- The arbiter registers all SRAM control signals and routes read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- AW, 12, SRAM word-address width.
- DW, 32, data width.
- MAX_HOLD, 16, maximum consecutive grants to one locked requester while another requester is waiting (legal range 1..255).

Ports:
- hclk  input  1  system clock.
- hresetn  input  1  asynchronous reset, active low.
- req  input  NUM_REQ  per-requester access request.
- lock  input  NUM_REQ  request to keep the grant on the next cycle (burst hold).
- wr  input  NUM_REQ  1 = write, 0 = read.
- addr  input  NUM_REQ*AW  packed word addresses; requester i uses bits [i*AW +: AW].
- wdata  input  NUM_REQ*DW  packed write data.
- gnt  output  NUM_REQ  one-hot, combinational; access accepted this cycle.
- rvalid  output  NUM_REQ  one-hot, registered; rdata is valid for requester i.
- rdata  output  DW  read data (sram_q passed through).
- sram_csn  output  1  SRAM chip select, active low.
- sram_wen  output  1  SRAM write enable, active low.
- sram_a  output  AW  SRAM address.
- sram_d  output  DW  SRAM write data.
- sram_q  input  DW  SRAM read data, registered inside the SRAM.

Behaviour:
- Reset values (asynchronous, hresetn low):
  - sram_csn = 1, sram_wen = 1, sram_a = 0, sram_d = 0.
  - rvalid = 0, owner = none, rr_ptr = NUM_REQ-1, hold_cnt = 0.
  - gnt = 0 while hresetn is low.
- Grant decision (combinational, each cycle):
  - Case 1 (hold): if the previous cycle granted requester k with lock[k]=1, and req[k]=1 now, and (hold_cnt < MAX_HOLD or no other req is set), then gnt = k.
  - Case 2 (round-robin): otherwise gnt = the first requester with req=1, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - No req set: gnt = 0.
- Accept edge (any gnt bit set):
  - sram_csn <= 0, sram_wen <= ~wr[g], sram_a <= addr[g], sram_d <= wdata[g].
  - rr_ptr <= g.
  - hold_cnt <= hold_cnt+1 if g equals the previous owner and the hold path was taken; otherwise hold_cnt <= 1.
- No grant:
  - sram_csn <= 1, sram_wen <= 1; sram_a and sram_d hold their values; hold_cnt <= 0.
- Throughput: one access per cycle. Back-to-back accesses from different requesters carry no bubble.
- Read latency:
  - Cycle T: gnt asserted.
  - Edge T+1: SRAM command registered.
  - Edge T+2: SRAM captures data.
  - rvalid[g] is high during cycle T+2 for exactly one cycle, with rdata = sram_q.
  - A two-stage pipeline of {valid, is_read, id} tracks outstanding reads. Writes produce no rvalid.
- Read-after-write: a write to address X followed by a read of X on the next cycle returns the new data; the SRAM ordering guarantees this and no forwarding is needed.
- Lock expiry: when the hold limit is reached and another requester is waiting, the grant moves to that requester on the next cycle. The locked requester then competes round-robin.
- Simultaneous requests with no lock active: requesters are served strictly in rotation, so no requester waits more than NUM_REQ-1 grants.
- Reset mid-access: the pipeline is cleared immediately, the in-flight rvalid is dropped, and the SRAM is deselected.
- Out-of-range requester bits: none possible for a legal NUM_REQ.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and output grant_cnt (NUM_REQ*16).
  - Each requester gets a 16-bit counter that increments on its gnt and saturates at 16'hFFFF.
  - stats_clr=1 zeroes all counters synchronously and takes priority over a same-cycle increment.
  - Counters reset to 0 on hresetn.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset and idle:
  - Stimulus: assert hresetn=0 during traffic, then release with req=0.
  - Response: sram_csn=1, sram_wen=1, gnt=0, rvalid=0 throughout.
- Single write then read:
  - Stimulus: req0 writes 0xDEADBEEF to addr 0x123; on the next cycle req0 reads addr 0x123.
  - Response: sram_wen=0 then 1; rvalid[0]=1 two cycles after the read grant; rdata=0xDEADBEEF.
- Round-robin, NUM_REQ=2:
  - Stimulus: req=2'b11 held with lock=0 for 6 cycles.
  - Response: gnt sequence 01,10,01,10,01,10; no idle cycles on sram_csn.
- Lock bound, MAX_HOLD=16:
  - Stimulus: req0 with lock0=1 for 40 cycles; req1 asserted from cycle 2.
  - Response: requester 0 receives 16 consecutive grants, then gnt=10 for one cycle, then the grant returns to requester 0.
- Read routing under interleave:
  - Stimulus: req0 reads 0x010 (holding 0x11111111) and req1 reads 0x020 (holding 0x22222222) on consecutive cycles.
  - Response: rvalid[0] with 0x11111111, then rvalid[1] with 0x22222222, on consecutive cycles.
- Stats (SRAM_ARB_STATS_EN):
  - Stimulus: 5 grants to requester 1, then stats_clr=1 in the same cycle as a grant.
  - Response: grant_cnt[1] reads 5, then 0.
